// File: rtl/reflet_uart_loader.sv
// Boot loader: receives a framed program image over 8N1 UART, writes it into
// instruction RAM and releases the CPU once a checksum-valid image is stored.
module reflet_uart_loader #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int addr_size = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 skip,
  output logic [addr_size-1:0] mem_addr,
  output logic [7:0]           mem_data,
  output logic                 mem_write_en,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error
);

  localparam int P    = clk_freq / baud_rate;
  localparam int HALF = P / 2;
  localparam int CW   = $clog2(P + 1);
  localparam logic [CW-1:0] P_M1 = CW'(P - 1);
  localparam logic [CW-1:0] H_M1 = CW'(HALF - 1);
  localparam logic [8:0] MAX_LEN = 9'(1 << addr_size);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_HDR, LEN, DATA, CSUM, DONE} state_t;

  logic            rx_s1, rx_s2, rx_prev;
  rx_state_t       rx_state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  // byte_valid / frame_err are one-cycle pulses towards the loader FSM; the
  // receiver has no backpressure, the FSM must accept a byte the cycle it is valid.
  logic            byte_valid;
  logic            frame_err;
  logic [7:0]      byte_data;

  state_t          state;
  logic [8:0]      len;
  logic [8:0]      idx;
  logic [7:0]      sum;
  logic [8:0]      eff_len;

  assign eff_len = (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      byte_data  <= '0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            cnt      <= '0;
          end
        end
        RX_START: begin
          if (cnt == H_M1) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == P_M1) begin
            cnt     <= '0;
            shift   <= {rx_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == P_M1) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_HDR;
      len          <= '0;
      idx          <= '0;
      sum          <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write_en <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      mem_write_en <= 1'b0;
      case (state)
        WAIT_HDR: begin
          if (skip) begin
            state    <= DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else if (frame_err) begin
            error <= 1'b1;
          end else if (byte_valid && byte_data == 8'hA5) begin
            error <= 1'b0;
            state <= LEN;
          end
        end
        LEN: begin
          if (frame_err) begin
            error <= 1'b1;
            state <= WAIT_HDR;
          end else if (byte_valid) begin
            if (eff_len > MAX_LEN) begin
              error <= 1'b1;
              state <= WAIT_HDR;
            end else begin
              len   <= eff_len;
              idx   <= '0;
              sum   <= '0;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (frame_err) begin
            error <= 1'b1;
            state <= WAIT_HDR;
          end else if (byte_valid) begin
            mem_addr     <= idx[addr_size-1:0];
            mem_data     <= byte_data;
            mem_write_en <= 1'b1;
            sum          <= sum + byte_data;
            idx          <= idx + 9'd1;
            if (idx + 9'd1 == len) state <= CSUM;
          end
        end
        CSUM: begin
          if (frame_err) begin
            error <= 1'b1;
            state <= WAIT_HDR;
          end else if (byte_valid) begin
            if (byte_data == sum) begin
              state    <= DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              error <= 1'b1;
              state <= WAIT_HDR;
            end
          end
        end
        DONE: ;
        default: state <= WAIT_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_uart_loader.sv
// Bench for reflet_uart_loader: serial frame driver, frame-level reference
// model feeding an expected-write queue, and a write monitor draining it.
module tb_reflet_uart_loader;

  localparam int P = 10;
  localparam int W = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       skip = 1'b0;
  logic [6:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_write_en;
  logic       cpu_hold;
  logic       done;
  logic       error;

  reflet_uart_loader #(.clk_freq(1000000), .baud_rate(100000), .addr_size(7)) dut (
    .clk(clk), .reset(reset), .rx(rx), .skip(skip),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write_en(mem_write_en),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [7:0]   tx_data[$];
  int           n_checks = 0;
  int           n_errors = 0;
  bit           model_done = 0;
  bit           model_error = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_write_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
      end else begin
        check("write", {17'd0, mem_addr, mem_data}, {17'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    model_done = 0;
    model_error = 0;
    exp_q.delete();
    idle(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    idle(P);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(P);
    end
    rx = stop_ok;
    idle(P);
    rx = 1'b1;
    idle(3);
  endtask

  function automatic logic [7:0] data_sum();
    logic [7:0] s = 8'd0;
    foreach (tx_data[i]) s += tx_data[i];
    return s;
  endfunction

  task automatic fill_random(input int n);
    tx_data.delete();
    for (int i = 0; i < n; i++) tx_data.push_back(8'($urandom_range(0, 255)));
  endtask

  // Frame-level model: a header clears error, an oversize length aborts, otherwise
  // each data byte becomes one write and the checksum decides done vs error.
  task automatic send_frame(input logic [7:0] len_b, input logic [7:0] csum_b);
    int n;
    n = (len_b == 8'd0) ? 256 : int'(len_b);
    send_byte(8'hA5, 1'b1);
    if (!model_done) model_error = 0;
    send_byte(len_b, 1'b1);
    if (n > 128) begin
      if (!model_done) model_error = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (!model_done) exp_q.push_back({7'(i), tx_data[i]});
        send_byte(tx_data[i], 1'b1);
      end
      send_byte(csum_b, 1'b1);
      if (!model_done) begin
        if (csum_b == data_sum()) model_done = 1;
        else model_error = 1;
      end
    end
    idle(5);
    check("done", {31'd0, done}, {31'd0, model_done});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !model_done});
    check("error", {31'd0, error}, {31'd0, model_error});
    check("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    idle(1);
    check("rst_addr", {25'd0, mem_addr}, 0);
    check("rst_data", {24'd0, mem_data}, 0);
    check("rst_we", {31'd0, mem_write_en}, 0);
    check("rst_hold", {31'd0, cpu_hold}, 1);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);

    // Glitch of 3 cycles is a false start.
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    check("glitch_error", {31'd0, error}, 0);
    check("glitch_done", {31'd0, done}, 0);

    // Framing error on a data byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h5A, 1'b0);
    idle(5);
    model_error = 1;
    check("frame_err_error", {31'd0, error}, 1);
    check("frame_err_nowrite", exp_q.size(), 0);

    // Bad checksum, then a good frame that clears error.
    tx_data = '{8'h01, 8'h02};
    send_frame(8'h02, 8'h04);
    tx_data = '{8'h7F};
    send_frame(8'h01, 8'h7F);

    // Oversize lengths, then a valid frame.
    do_reset();
    send_frame(8'h81, 8'h00);
    send_frame(8'h00, 8'h00);
    fill_random(5);
    send_frame(8'h05, data_sum());

    // Reference frame.
    do_reset();
    tx_data = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h03, 8'h66);

    // Reset in the middle of DATA, then a full 128-byte image.
    do_reset();
    fill_random(4);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({7'(i), tx_data[i]});
      send_byte(tx_data[i], 1'b1);
    end
    idle(5);
    check("mid_writes", exp_q.size(), 0);
    reset = 1'b1;
    idle(1);
    check("mid_rst_addr", {25'd0, mem_addr}, 0);
    check("mid_rst_data", {24'd0, mem_data}, 0);
    check("mid_rst_hold", {31'd0, cpu_hold}, 1);
    check("mid_rst_error", {31'd0, error}, 0);
    reset = 1'b0;
    model_done = 0;
    model_error = 0;
    idle(2);
    fill_random(128);
    send_frame(8'd128, data_sum());

    // Skip releases the CPU immediately; later frames write nothing.
    do_reset();
    skip = 1'b1;
    idle(1);
    skip = 1'b0;
    model_done = 1;
    check("skip_done", {31'd0, done}, 1);
    check("skip_hold", {31'd0, cpu_hold}, 0);
    fill_random(3);
    send_frame(8'h03, data_sum());

    // Randomised frames with good or corrupted checksums.
    for (int k = 0; k < 6; k++) begin
      int n;
      logic [7:0] c;
      do_reset();
      n = $urandom_range(1, 12);
      fill_random(n);
      c = data_sum();
      if ($urandom_range(0, 1) == 1) c = c + 8'($urandom_range(1, 255));
      send_frame(8'(n), c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reflet_uart_loader.md
Name: reflet_uart_loader

Overview:
- Boot-time program loader that sits upstream of the 8-bit controller's instruction memory (0x00–0x7F).
- Receives a framed program image over UART `rx` and writes it byte by byte into instruction RAM through a dedicated write port.
- Holds the CPU in reset until a complete image with a valid checksum has been stored, then releases the CPU permanently until the next reset.
- Contains its own 8N1 receiver, so it has no dependency on the UART peripheral.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, UART bit rate; bit period P = clk_freq/baud_rate cycles, integer, truncated; P >= 4 required.
- addr_size, 7, width of the instruction-memory address; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  UART serial input, idle high, asynchronous to clk.
- skip  input  1  when high in WAIT_HDR, go straight to DONE without loading.
- mem_addr  output  addr_size  instruction-memory write address.
- mem_data  output  8  instruction-memory write data.
- mem_write_en  output  1  one-cycle write strobe.
- cpu_hold  output  1  high keeps the CPU in reset.
- done  output  1  high once the image is accepted or `skip` is taken.
- error  output  1  sticky error flag; cleared when a new header byte is received.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: mem_addr=0, mem_data=0, mem_write_en=0, cpu_hold=1, done=0, error=0. State is WAIT_HDR; the receiver is idle and all counters are 0.
- Reset mid-load: returns to the reset state. Memory already written is not cleared.
- rx synchronizer: rx passes through a 2-flop synchronizer; all receiver logic uses the synchronized value.
- Receiver start detection: a falling edge of synchronized rx starts a frame. rx is resampled P/2 cycles later; if it is high, this is a false start and the receiver returns to idle with no byte emitted.
- Receiver data and stop bits: 8 data bits, LSB first, each sampled P cycles after the previous sample. Then the stop bit is sampled P cycles later.
  - Stop bit = 1: the receiver emits byte_valid for one cycle.
  - Stop bit = 0: framing error. No byte is emitted, error is set, and the FSM returns to WAIT_HDR.
- Receiver re-arm: after the stop-bit sample, the receiver watches for the next falling edge immediately.
- Frame format: header 0xA5, then length L, then L data bytes, then checksum C.
- Length encoding: L=0 encodes 256. The effective length must be <= 2^addr_size.
- Checksum rule: C must equal the sum of the data bytes mod 256.
- FSM:
  - WAIT_HDR:
    - skip=1 → DONE.
    - Byte 0xA5 → clear error, then LEN.
    - Any other byte is ignored.
  - LEN:
    - Effective length N > 2^addr_size → set error, go to WAIT_HDR.
    - Otherwise latch N, clear the index and sum, go to DATA.
  - DATA:
    - On each byte: the next cycle drives mem_addr=index, mem_data=byte, mem_write_en=1.
    - The sum is updated mod 256 and the index increments.
    - After the N-th write → CSUM.
    - The index never wraps, because N <= 2^addr_size.
  - CSUM:
    - Byte == sum → DONE.
    - Otherwise set error and go to WAIT_HDR. Written bytes remain in memory; a new frame overwrites them.
  - DONE:
    - cpu_hold=0 and done=1, registered and asserted the cycle after entry.
    - rx and skip are ignored.
    - DONE is exited only by reset.
- Write strobe: mem_write_en is never high outside DATA. mem_addr and mem_data hold their last values when the strobe is low.
- Write latency: the strobe is asserted exactly 1 cycle after byte_valid.
- Write rate: one write per received byte. With 10 bits per byte, writes are at least 10·P cycles apart.
- skip vs byte: if skip=1 and byte_valid occur in the same WAIT_HDR cycle, skip wins.

Test Plan:
Common settings: clk_freq=1000000, baud_rate=100000 (P=10), addr_size=7.
1. Frame A5 03 11 22 33 66 → exactly three write strobes: (0,0x11), (1,0x22), (2,0x33). cpu_hold falls and done rises 1 cycle after the checksum stop bit. error=0.
2. Frame A5 02 01 02 04 (bad checksum) → writes (0,0x01), (1,0x02), error=1, cpu_hold stays 1. Then the frame A5 01 7F 7F → error clears on the A5, write (0,0x7F), done=1.
3. Length byte 0x81 (129 > 128), and separately 0x00 (256) → error=1, no writes, FSM back in WAIT_HDR. A subsequent valid frame loads normally.
4. Glitch: rx low for 3 cycles → no byte, no state change. Stop bit forced 0 during a data byte → error=1, no write for that byte, FSM in WAIT_HDR.
5. skip=1 held one cycle after reset → done=1, cpu_hold=0 the next cycle. A following full frame produces no mem_write_en.
6. Reset asserted mid-DATA after 2 of 4 writes → all outputs return to reset values the following cycle. A subsequent full 128-byte frame writes addresses 0..127 in order, then done=1.
